// File: rtl/kernel_dispatch_arb.sv
// Kernel dispatch arbiter: pulls descriptors and starts free kernels round-robin,
// then serialises kernel completions into a held record stream for the completion sink.
module kernel_dispatch_arb #(
    parameter int KERNEL_NUM  = 2,
    parameter int DSC_WIDTH   = 1024,
    parameter int RCODE_WIDTH = 8,
    parameter int KIDX_WIDTH  = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              dispatch_en_i,
    input  logic                              dsc_ready_i,
    output logic                              dsc_pull_o,
    input  logic [DSC_WIDTH-1:0]              dsc_data_i,
    output logic [KERNEL_NUM-1:0]             engine_start,
    output logic [DSC_WIDTH-1:0]              jd_payload,
    input  logic [KERNEL_NUM-1:0]             engine_done,
    input  logic [KERNEL_NUM*RCODE_WIDTH-1:0] return_code,
    output logic                              cmpl_push_o,
    input  logic                              cmpl_ready_i,
    output logic [KIDX_WIDTH-1:0]             cmpl_kidx_o,
    output logic [RCODE_WIDTH-1:0]            cmpl_code_o,
    output logic [15:0]                       cmpl_tag_o,
    output logic [KERNEL_NUM-1:0]             busy_o,
    output logic [31:0]                       job_cnt_o,
    output logic [31:0]                       cmpl_cnt_o,
    output logic                              err_o
);

    typedef enum logic [1:0] {IDLE, PULL, LOAD, START} state_t;

    state_t                 state;
    logic [KIDX_WIDTH-1:0]  target;
    logic [KIDX_WIDTH-1:0]  rr_ptr;
    logic [KIDX_WIDTH-1:0]  cmpl_ptr;
    logic [15:0]            job_tag;
    logic [KERNEL_NUM-1:0]  pend;
    logic [RCODE_WIDTH-1:0] code_q [KERNEL_NUM];
    logic [15:0]            tag_q  [KERNEL_NUM];

    logic                   hs;
    logic [KIDX_WIDTH-1:0]  scan_ptr;
    logic [KIDX_WIDTH:0]    disp_pick;
    logic [KIDX_WIDTH:0]    cmpl_pick;
    logic [KERNEL_NUM-1:0]  target_mask;
    logic [KERNEL_NUM-1:0]  rec_mask;
    logic [RCODE_WIDTH-1:0] sel_code;
    logic [15:0]            sel_tag;

    function automatic logic [KIDX_WIDTH-1:0] wrap_inc(input logic [KIDX_WIDTH-1:0] idx);
        return (idx == KIDX_WIDTH'(KERNEL_NUM - 1)) ? '0 : idx + 1'b1;
    endfunction

    // Returns {found, index} of the first set bit at or after start, wrapping.
    function automatic logic [KIDX_WIDTH:0] pick(input logic [KERNEL_NUM-1:0] vec,
                                                 input logic [KIDX_WIDTH-1:0] start);
        logic [KIDX_WIDTH:0] r;
        int j;
        r = '0;
        for (int i = KERNEL_NUM - 1; i >= 0; i--) begin
            j = (int'(start) + i) % KERNEL_NUM;
            if (vec[j]) r = {1'b1, KIDX_WIDTH'(j)};
        end
        return r;
    endfunction

    assign hs        = cmpl_push_o & cmpl_ready_i;
    assign scan_ptr  = hs ? wrap_inc(cmpl_kidx_o) : cmpl_ptr;
    assign disp_pick = pick(~busy_o, rr_ptr);
    // The record being handed off is still pending this cycle; keep it out of the scan.
    assign cmpl_pick = pick(pend & ~rec_mask, scan_ptr);

    always_comb begin
        target_mask = '0;
        rec_mask    = '0;
        for (int k = 0; k < KERNEL_NUM; k++) begin
            target_mask[k] = (target == KIDX_WIDTH'(k));
            rec_mask[k]    = hs && (cmpl_kidx_o == KIDX_WIDTH'(k));
        end
    end

    always_comb begin
        sel_code = '0;
        sel_tag  = '0;
        for (int k = 0; k < KERNEL_NUM; k++) begin
            if (cmpl_pick[KIDX_WIDTH-1:0] == KIDX_WIDTH'(k)) begin
                sel_code = code_q[k];
                sel_tag  = tag_q[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            dsc_pull_o   <= 1'b0;
            engine_start <= '0;
            jd_payload   <= '0;
            target       <= '0;
            rr_ptr       <= '0;
            job_tag      <= '0;
            job_cnt_o    <= '0;
        end else begin
            dsc_pull_o   <= 1'b0;
            engine_start <= '0;
            case (state)
                IDLE: begin
                    if (dispatch_en_i && dsc_ready_i && disp_pick[KIDX_WIDTH]) begin
                        state      <= PULL;
                        target     <= disp_pick[KIDX_WIDTH-1:0];
                        dsc_pull_o <= 1'b1;
                    end
                end
                PULL: state <= LOAD;
                LOAD: begin
                    state        <= START;
                    jd_payload   <= dsc_data_i;
                    engine_start <= target_mask;
                end
                START: begin
                    state     <= IDLE;
                    job_tag   <= job_tag + 16'd1;
                    job_cnt_o <= job_cnt_o + 32'd1;
                    rr_ptr    <= wrap_inc(target);
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_o <= '0;
            pend   <= '0;
            err_o  <= 1'b0;
            for (int k = 0; k < KERNEL_NUM; k++) begin
                code_q[k] <= '0;
                tag_q[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < KERNEL_NUM; k++) begin
                if (engine_done[k]) begin
                    if (busy_o[k] && !pend[k]) begin
                        pend[k]   <= 1'b1;
                        code_q[k] <= return_code[k*RCODE_WIDTH +: RCODE_WIDTH];
                    end else begin
                        err_o <= 1'b1;
                    end
                end
                if (rec_mask[k]) begin
                    pend[k]   <= 1'b0;
                    busy_o[k] <= 1'b0;
                end
                if (state == START && target_mask[k]) begin
                    busy_o[k] <= 1'b1;
                    tag_q[k]  <= job_tag;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cmpl_push_o <= 1'b0;
            cmpl_kidx_o <= '0;
            cmpl_code_o <= '0;
            cmpl_tag_o  <= '0;
            cmpl_ptr    <= '0;
            cmpl_cnt_o  <= '0;
        end else begin
            if (hs) begin
                cmpl_ptr   <= scan_ptr;
                cmpl_cnt_o <= cmpl_cnt_o + 32'd1;
            end
            if (!cmpl_push_o || hs) begin
                cmpl_push_o <= cmpl_pick[KIDX_WIDTH];
                if (cmpl_pick[KIDX_WIDTH]) begin
                    cmpl_kidx_o <= cmpl_pick[KIDX_WIDTH-1:0];
                    cmpl_code_o <= sel_code;
                    cmpl_tag_o  <= sel_tag;
                end
            end
        end
    end

endmodule

// File: tb/tb_kernel_dispatch_arb.sv
// Bench for kernel_dispatch_arb: directed scenarios plus randomized traffic,
// all checked every cycle against a transaction-level model of the arbiter.
module tb_kernel_dispatch_arb;

    localparam int K  = 2;
    localparam int DW = 64;
    localparam int RW = 8;
    localparam int KW = 4;

    logic          clk;
    logic          reset;
    logic          dispatch_en_i;
    logic          dsc_ready_i;
    logic          dsc_pull_o;
    logic [DW-1:0] dsc_data_i;
    logic [K-1:0]  engine_start;
    logic [DW-1:0] jd_payload;
    logic [K-1:0]  engine_done;
    logic [K*RW-1:0] return_code;
    logic          cmpl_push_o;
    logic          cmpl_ready_i;
    logic [KW-1:0] cmpl_kidx_o;
    logic [RW-1:0] cmpl_code_o;
    logic [15:0]   cmpl_tag_o;
    logic [K-1:0]  busy_o;
    logic [31:0]   job_cnt_o;
    logic [31:0]   cmpl_cnt_o;
    logic          err_o;

    kernel_dispatch_arb #(
        .KERNEL_NUM(K), .DSC_WIDTH(DW), .RCODE_WIDTH(RW), .KIDX_WIDTH(KW)
    ) dut (
        .clk(clk), .reset(reset), .dispatch_en_i(dispatch_en_i), .dsc_ready_i(dsc_ready_i),
        .dsc_pull_o(dsc_pull_o), .dsc_data_i(dsc_data_i), .engine_start(engine_start),
        .jd_payload(jd_payload), .engine_done(engine_done), .return_code(return_code),
        .cmpl_push_o(cmpl_push_o), .cmpl_ready_i(cmpl_ready_i), .cmpl_kidx_o(cmpl_kidx_o),
        .cmpl_code_o(cmpl_code_o), .cmpl_tag_o(cmpl_tag_o), .busy_o(busy_o),
        .job_cnt_o(job_cnt_o), .cmpl_cnt_o(cmpl_cnt_o), .err_o(err_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    // Model: the job in flight is a phase number (0 idle, 1 pull, 2 load, 3 start).
    int            m_phase, m_tgt, m_rr, m_cptr, m_rk;
    logic [K-1:0]  m_busy, m_pend;
    logic [RW-1:0] m_code [K];
    logic [15:0]   m_ktag [K];
    logic [15:0]   m_tag, m_rtag;
    logic [31:0]   m_jobs, m_cmpls;
    logic [DW-1:0] m_payload;
    logic          m_err, m_rv;
    logic [RW-1:0] m_rcode;

    function automatic int first_from(input logic [K-1:0] v, input int s);
        for (int i = 0; i < K; i++)
            if (v[(s + i) % K]) return (s + i) % K;
        return -1;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: actual %0h, required %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_step();
        logic [K-1:0] ob, op, cand;
        logic hs, old_rv;
        int old_rk, f;
        if (reset) begin
            m_phase = 0; m_tgt = 0; m_rr = 0; m_cptr = 0; m_rk = 0;
            m_busy = '0; m_pend = '0; m_tag = '0; m_rtag = '0; m_rcode = '0;
            m_jobs = '0; m_cmpls = '0; m_payload = '0; m_err = 1'b0; m_rv = 1'b0;
            for (int k = 0; k < K; k++) begin m_code[k] = '0; m_ktag[k] = '0; end
            return;
        end
        ob = m_busy; op = m_pend; old_rv = m_rv; old_rk = m_rk;
        hs = m_rv && cmpl_ready_i;
        for (int k = 0; k < K; k++) begin
            if (engine_done[k]) begin
                if (ob[k] && !op[k]) begin
                    m_pend[k] = 1'b1;
                    m_code[k] = return_code[k*RW +: RW];
                end else begin
                    m_err = 1'b1;
                end
            end
        end
        if (hs) begin
            m_pend[old_rk] = 1'b0;
            m_busy[old_rk] = 1'b0;
            m_cptr = (old_rk + 1) % K;
            m_cmpls++;
        end
        if (!old_rv || hs) begin
            cand = op;
            if (hs) cand[old_rk] = 1'b0;
            f = first_from(cand, m_cptr);
            m_rv = (f >= 0);
            if (f >= 0) begin
                m_rk = f; m_rcode = m_code[f]; m_rtag = m_ktag[f];
            end
        end
        case (m_phase)
            0: begin
                f = first_from(~ob, m_rr);
                if (dispatch_en_i && dsc_ready_i && f >= 0) begin
                    m_tgt = f; m_phase = 1;
                end
            end
            1: m_phase = 2;
            2: begin m_payload = dsc_data_i; m_phase = 3; end
            default: begin
                m_busy[m_tgt] = 1'b1;
                m_ktag[m_tgt] = m_tag;
                m_tag++;
                m_jobs++;
                m_rr = (m_tgt + 1) % K;
                m_phase = 0;
            end
        endcase
    endtask

    task automatic compare();
        chk("pull", dsc_pull_o, m_phase == 1);
        chk("start", engine_start, (m_phase == 3) ? (1 << m_tgt) : 0);
        chk("payload", jd_payload, m_payload);
        chk("busy", busy_o, m_busy);
        chk("push", cmpl_push_o, m_rv);
        if (m_rv) begin
            chk("kidx", cmpl_kidx_o, m_rk);
            chk("code", cmpl_code_o, m_rcode);
            chk("tag", cmpl_tag_o, m_rtag);
        end
        chk("job_cnt", job_cnt_o, m_jobs);
        chk("cmpl_cnt", cmpl_cnt_o, m_cmpls);
        chk("err", err_o, m_err);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        compare();
    endtask

    task automatic wait_pull(input int lim);
        int n = 0;
        do begin cycle(); n++; end while (!dsc_pull_o && n < lim);
        chk("pull_timeout", dsc_pull_o, 1);
    endtask

    task automatic wait_start(input int lim);
        int n = 0;
        do begin cycle(); n++; end while (engine_start == '0 && n < lim);
        chk("start_timeout", engine_start != '0, 1);
    endtask

    logic [DW-1:0] a5;

    initial begin
        a5 = {8{8'hA5}};
        reset = 1'b1; dispatch_en_i = 1'b0; dsc_ready_i = 1'b0; dsc_data_i = '0;
        engine_done = '0; return_code = '0; cmpl_ready_i = 1'b0;
        repeat (3) cycle();
        chk("rst_pull", dsc_pull_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_push", cmpl_push_o, 0);
        chk("rst_jobs", job_cnt_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_payload", jd_payload, 0);

        // Two jobs with descriptors always available and no completions.
        reset = 1'b0; dispatch_en_i = 1'b1; dsc_ready_i = 1'b1; cmpl_ready_i = 1'b1;
        dsc_data_i = a5;
        wait_pull(10);
        cycle();
        cycle();
        chk("a_start0", engine_start, 2'b01);
        chk("a_payload", jd_payload, a5);
        dsc_data_i = 64'h0123_4567_89AB_CDEF;
        wait_start(10);
        chk("a_start1", engine_start, 2'b10);
        repeat (10) cycle();
        chk("a_pull_idle", dsc_pull_o, 0);
        chk("a_jobs", job_cnt_o, 2);
        chk("a_busy", busy_o, 2'b11);

        // Simultaneous completions drain back-to-back.
        dispatch_en_i = 1'b0;
        engine_done = 2'b11; return_code = {8'h22, 8'h11};
        cycle();
        engine_done = '0; return_code = '0;
        cycle();
        chk("b_push0", cmpl_push_o, 1);
        chk("b_kidx0", cmpl_kidx_o, 0);
        chk("b_code0", cmpl_code_o, 8'h11);
        chk("b_tag0", cmpl_tag_o, 0);
        cycle();
        chk("b_push1", cmpl_push_o, 1);
        chk("b_kidx1", cmpl_kidx_o, 1);
        chk("b_code1", cmpl_code_o, 8'h22);
        chk("b_tag1", cmpl_tag_o, 1);
        cycle();
        chk("b_push_off", cmpl_push_o, 0);
        chk("b_busy", busy_o, 2'b00);
        chk("b_cmpls", cmpl_cnt_o, 2);

        // Back-pressured record holds its kernel busy until accepted.
        cmpl_ready_i = 1'b0; dispatch_en_i = 1'b1;
        begin
            int n = 0;
            do begin cycle(); n++; end while (busy_o != 2'b11 && n < 20);
        end
        chk("c_busy", busy_o, 2'b11);
        engine_done = 2'b01; return_code = {8'h00, 8'h33};
        cycle();
        engine_done = '0;
        cycle();
        for (int i = 0; i < 10; i++) begin
            chk("c_hold_push", cmpl_push_o, 1);
            chk("c_hold_kidx", cmpl_kidx_o, 0);
            chk("c_hold_code", cmpl_code_o, 8'h33);
            chk("c_hold_tag", cmpl_tag_o, 2);
            chk("c_hold_start", engine_start, 0);
            cycle();
        end
        chk("c_busy_held", busy_o, 2'b11);
        cmpl_ready_i = 1'b1;
        cycle();
        chk("c_busy_freed", busy_o, 2'b10);
        wait_start(10);
        chk("c_restart", engine_start, 2'b01);
        cycle();
        chk("c_jobs", job_cnt_o, 5);
        chk("c_busy_again", busy_o, 2'b11);

        // Done on an idle kernel.
        reset = 1'b1; dispatch_en_i = 1'b0;
        repeat (2) cycle();
        reset = 1'b0;
        engine_done = 2'b01; return_code = {8'h00, 8'h44};
        cycle();
        engine_done = '0;
        chk("d_err", err_o, 1);
        repeat (3) begin
            cycle();
            chk("d_nopush", cmpl_push_o, 0);
        end
        chk("d_err_sticky", err_o, 1);

        // Reset in LOAD abandons the job.
        reset = 1'b1;
        cycle();
        reset = 1'b0; dispatch_en_i = 1'b1; dsc_ready_i = 1'b1; dsc_data_i = a5;
        wait_pull(10);
        cycle();
        reset = 1'b1;
        cycle();
        chk("e_start", engine_start, 0);
        chk("e_pull", dsc_pull_o, 0);
        chk("e_payload", jd_payload, 0);
        chk("e_jobs", job_cnt_o, 0);
        chk("e_busy", busy_o, 0);
        chk("e_err", err_o, 0);
        cycle();
        chk("e_start_late", engine_start, 0);
        reset = 1'b0; dispatch_en_i = 1'b0;

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            reset         = ($urandom_range(0, 399) == 0);
            dispatch_en_i = ($urandom_range(0, 3) != 0);
            dsc_ready_i   = ($urandom_range(0, 2) != 0);
            dsc_data_i    = {$urandom, $urandom};
            cmpl_ready_i  = ($urandom_range(0, 2) != 0);
            return_code   = 16'($urandom);
            for (int k = 0; k < K; k++)
                engine_done[k] = m_busy[k] && !m_pend[k] && ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 799) == 0)
                engine_done[$urandom_range(0, K - 1)] = 1'b1;
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/kernel_dispatch_arb.md
KERNEL_DISPATCH_ARB -- requirements
Module: kernel_dispatch_arb

Interface
REQ-001 SHALL have parameter KERNEL_NUM, default 2: number of kernels, 2..16.
REQ-002 SHALL have parameter DSC_WIDTH, default 1024: descriptor/payload width.
REQ-003 SHALL have parameter RCODE_WIDTH, default 8: per-kernel return code width.
REQ-004 SHALL have parameter KIDX_WIDTH, default 4: kernel index width, >= clog2(KERNEL_NUM).
REQ-005 SHALL have port clk  in  1: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port reset  in  1: synchronous, active-high reset.
REQ-007 SHALL have port dispatch_en_i  in  1: when high, new jobs may be dispatched.
REQ-008 SHALL have port dsc_ready_i  in  1: descriptor source holds at least one descriptor.
REQ-009 SHALL have port dsc_pull_o  out  1: one-cycle pop of one descriptor.
REQ-010 SHALL have port dsc_data_i  in  DSC_WIDTH: descriptor, valid the cycle after dsc_pull_o.
REQ-011 SHALL have port engine_start  out  KERNEL_NUM: one-hot, one-cycle start pulse.
REQ-012 SHALL have port jd_payload  out  DSC_WIDTH: shared payload bus to the kernels.
REQ-013 SHALL have port engine_done  in  KERNEL_NUM: one-cycle done pulse per kernel.
REQ-014 SHALL have port return_code  in  KERNEL_NUM*RCODE_WIDTH: code of kernel k in slice k, valid with its done pulse.
REQ-015 SHALL have port cmpl_push_o  out  1: completion record valid.
REQ-016 SHALL have port cmpl_ready_i  in  1: completion sink accepts the record.
REQ-017 SHALL have port cmpl_kidx_o  out  KIDX_WIDTH: kernel index of the record.
REQ-018 SHALL have port cmpl_code_o  out  RCODE_WIDTH: return code of the record.
REQ-019 SHALL have port cmpl_tag_o  out  16: job tag of the record.
REQ-020 SHALL have port busy_o  out  KERNEL_NUM: per-kernel busy.
REQ-021 SHALL have port job_cnt_o  out  32: jobs dispatched.
REQ-022 SHALL have port cmpl_cnt_o  out  32: completions accepted.
REQ-023 SHALL have port err_o  out  1: sticky protocol error.

Function
REQ-024 SHALL run the dispatch FSM IDLE->PULL->LOAD->START->IDLE, one cycle in each of PULL, LOAD and START.
REQ-025 SHALL leave IDLE only when dispatch_en_i=1, dsc_ready_i=1 and at least one kernel has busy_o=0.
REQ-026 SHALL, on the IDLE->PULL transition, latch as target the first non-busy kernel at or after rr_ptr, searching upward modulo KERNEL_NUM.
REQ-027 SHALL drive dsc_pull_o=1 only in PULL.
REQ-028 SHALL, in LOAD, capture dsc_data_i into the payload register.
REQ-029 SHALL, in START, drive engine_start[target]=1 with jd_payload equal to the captured descriptor.
REQ-030 SHALL hold jd_payload until the next LOAD.
REQ-031 SHALL, on the START cycle edge, do all of the following: set busy[target]; store the current job tag for target; increment the job tag (16 b, wraps 0xFFFF->0); increment job_cnt_o (wraps); set rr_ptr to (target+1) mod KERNEL_NUM.
REQ-032 SHALL give a pull-to-start latency of exactly 2 cycles and a minimum of 4 cycles per job.
REQ-033 SHALL let a job already past IDLE complete its sequence if dispatch_en_i drops.
REQ-034 SHALL, for engine_done[k] with busy[k]=1, set pend[k] and capture slice k of return_code.
REQ-035 SHALL ignore engine_done[k] when busy[k]=0 or pend[k]=1, and set err_o, which stays high until reset.
REQ-036 SHALL treat engine_done[k] in the same cycle as engine_start[k] as the error case of REQ-035, since busy is not yet set.
REQ-037 SHALL register all simultaneous valid done pulses in the same cycle; none may be lost.
REQ-038 SHALL, when the output register is empty or handshaking, load the first pending kernel at or after cmpl_ptr into the completion output register, with cmpl_push_o registered.
REQ-039 SHALL hold cmpl_push_o and all record fields stable until cmpl_ready_i=1.
REQ-040 SHALL, on a completion handshake, do all of the following: clear pend[k] and busy[k]; set cmpl_ptr to (k+1) mod KERNEL_NUM; increment cmpl_cnt_o (wraps).
REQ-041 SHALL sustain back-to-back records, one per cycle, while records are pending and cmpl_ready_i=1.
REQ-042 SHALL make a kernel freed by a handshake eligible for dispatch from the next cycle.

Reset
REQ-043 SHALL, while reset=1, force the FSM to IDLE and set to 0 all of the following: dsc_pull_o, engine_start, jd_payload, busy, pend, cmpl_push_o, record fields, rr_ptr, cmpl_ptr, job tag, job_cnt_o, cmpl_cnt_o, err_o.
REQ-044 SHALL abandon an in-flight dispatch on reset mid-sequence without issuing engine_start.

Verification
REQ-045 SHALL cover: KERNEL_NUM=2, dsc_ready_i held 1, no done -> starts on kernel 0 then kernel 1, then dsc_pull_o stays 0; job_cnt_o=2.
REQ-046 SHALL cover: pull at cycle T with dsc_data_i=0xA5... at T+1 -> engine_start=01 at T+2 and jd_payload=0xA5...
REQ-047 SHALL cover: kernels 0 and 1 busy, simultaneous done with codes 0x11 and 0x22, cmpl_ready_i=1 -> records (0,0x11,tag0) then (1,0x22,tag1) on consecutive cycles; busy_o=00.
REQ-048 SHALL cover: cmpl_ready_i=0 for 10 cycles -> record held stable and no dispatch to that kernel; ready high -> handshake, then the kernel is restarted.
REQ-049 SHALL cover: done on an idle kernel -> err_o=1, no record issued.
REQ-050 SHALL cover: reset asserted in LOAD -> no engine_start and all outputs 0; job_cnt_o=0.
